// File: rtl/route_demux_buf_if.sv
// Handshake bundle for route_demux_buf: flit input, route token,
// per-port flit output, counter clear/readback and busy status.
interface route_demux_buf_if #(
    parameter int DATA_W  = 9,
    parameter int NUM_OUT = 2,
    parameter int CNT_W   = 16
);
    localparam int SEL_W = $clog2(NUM_OUT);

    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic                     sel_valid;
    logic                     sel_ready;
    logic [SEL_W-1:0]         sel_data;
    logic [NUM_OUT-1:0]       out_valid;
    logic [NUM_OUT-1:0]       out_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     cnt_clr;
    logic [NUM_OUT*CNT_W-1:0] pkt_count;
    logic                     busy;

    modport master (
        output in_valid, in_data, sel_ready, out_ready, cnt_clr,
        input  in_ready, sel_valid, sel_data, out_valid, out_data,
        input  pkt_count, busy
    );

    modport slave (
        input  in_valid, in_data, sel_ready, out_ready, cnt_clr,
        output in_ready, sel_valid, sel_data, out_valid, out_data,
        output pkt_count, busy
    );
endinterface

// File: rtl/route_demux_buf.sv
// Buffered NoC tree-node router: FIFO-fed, emits a route token before
// each flit, steers it to one output port and keeps per-port counts.
module route_demux_buf #(
    parameter int                DATA_W    = 9,
    parameter int                ADDR_LSB  = 5,
    parameter int                ADDR_W    = 4,
    parameter int                NUM_OUT   = 2,
    parameter int                LEVEL     = 0,
    parameter int                LEAF      = 0,
    parameter logic [ADDR_W-1:0] NODE_ADDR = 4'b0100,
    parameter logic [ADDR_W-1:0] NODE_MASK = 4'b1100,
    parameter int                DEPTH     = 2,
    parameter int                CNT_W     = 16
) (
    input logic              clk,
    input logic              rst_n,
    route_demux_buf_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_OUT);
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;

    typedef enum logic [1:0] {IDLE, SEL, DATA} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0] flit_q;
    logic [SEL_W-1:0]  port_q;
    logic              rdy_q;
    logic              empty, full, push, pop, deliver;
    logic [DATA_W-1:0] head;
    logic [SEL_W-1:0]  head_port;

    // Extra pointer MSB separates full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = bus.in_valid & bus.in_ready;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    generate
        if (LEAF != 0) begin : g_leaf
            logic [ADDR_W-1:0] addr;
            assign addr      = head[ADDR_LSB +: ADDR_W];
            assign head_port = ((addr & NODE_MASK) == NODE_ADDR) ?
                               '0 : SEL_W'(1);
        end else begin : g_tree
            assign head_port =
                head[ADDR_LSB+ADDR_W-1-LEVEL*SEL_W -: SEL_W];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        deliver = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = SEL;
                end
            end
            SEL: begin
                if (bus.sel_ready) state_d = DATA;
            end
            DATA: begin
                if (bus.out_ready[port_q]) begin
                    deliver = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = SEL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            flit_q   <= '0;
            port_q   <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                flit_q   <= head;
                port_q   <= head_port;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.in_data;
    end

    // Clear beats a same-cycle increment; counts stick at all-ones.
    for (genvar p = 0; p < NUM_OUT; p++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (bus.cnt_clr) begin
                cnt_q <= '0;
            end else if (deliver && port_q == SEL_W'(p) && cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
        assign bus.pkt_count[p*CNT_W +: CNT_W] = cnt_q;
    end

    assign bus.in_ready  = rdy_q & ~full;
    assign bus.sel_valid = (state_q == SEL);
    assign bus.sel_data  = (state_q == SEL) ? port_q : '0;
    assign bus.out_valid = (state_q == DATA) ? (NUM_OUT'(1) << port_q) : '0;
    assign bus.out_data  = (state_q == DATA) ? flit_q : '0;
    assign bus.busy      = (state_q != IDLE) | ~empty;
endmodule

// File: tb/tb_route_demux_buf.sv
// Bench for route_demux_buf: tree node (LEVEL=2, CNT_W=2) with a
// scoreboard monitor, plus a leaf node for address/mask routing.
module tb_route_demux_buf;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   cyc;

    typedef struct {
        logic [8:0] data;
        logic       port;
    } exp_t;

    exp_t sb[$];
    int   deliv_cyc[$];
    int   exp_cnt[2];
    bit   tok_ok;

    route_demux_buf_if #(.DATA_W(9), .NUM_OUT(2), .CNT_W(2))  bm();
    route_demux_buf_if #(.DATA_W(9), .NUM_OUT(2), .CNT_W(16)) bl();

    route_demux_buf #(.LEVEL(2), .CNT_W(2)) u_tree (
        .clk(clk), .rst_n(rst_n), .bus(bm)
    );

    route_demux_buf #(.LEAF(1)) u_leaf (
        .clk(clk), .rst_n(rst_n), .bus(bl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, sb=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor for the tree node, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bm.sel_valid && bm.sel_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sel_token: got token %0d, none expected",
                             bm.sel_data);
                end else if (bm.sel_data !== sb[0].port) begin
                    n_fail++;
                    $display("FAIL sel_token: got %0d want %0d",
                             bm.sel_data, sb[0].port);
                end
                tok_ok = 1'b1;
            end
            if (bm.out_valid != 2'b00) begin
                n_checks++;
                if (!tok_ok) begin
                    n_fail++;
                    $display("FAIL order: out_valid %b before token",
                             bm.out_valid);
                end
                if ((bm.out_valid & bm.out_ready) != 2'b00) begin
                    exp_t       e;
                    logic [1:0] ev;
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL deliver: got %h, none expected",
                                 bm.out_data);
                    end else begin
                        e  = sb.pop_front();
                        ev = 2'b01 << e.port;
                        if (bm.out_valid !== ev || bm.out_data !== e.data) begin
                            n_fail++;
                            $display("FAIL deliver: got v=%b d=%h want v=%b d=%h",
                                     bm.out_valid, bm.out_data, ev, e.data);
                        end
                        if (!bm.cnt_clr && exp_cnt[e.port] < 3)
                            exp_cnt[e.port]++;
                    end
                    tok_ok = 1'b0;
                    deliv_cyc.push_back(cyc);
                end
            end
            if (bm.cnt_clr) begin
                exp_cnt[0] = 0;
                exp_cnt[1] = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_flit(input logic [8:0] d);
        exp_t e;
        bm.in_valid = 1'b1;
        bm.in_data  = d;
        for (int i = 0; i < 50; i++) begin
            if (bm.in_ready) break;
            tick();
        end
        n_checks++;
        if (!bm.in_ready) begin
            n_fail++;
            $display("FAIL push_timeout: in_ready=%b want 1 for %h",
                     bm.in_ready, d);
            bm.in_valid = 1'b0;
            return;
        end
        e.data = d;
        e.port = d[6];
        sb.push_back(e);
        tick();
        bm.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0 && !bm.busy) break;
            tick();
        end
        n_checks++;
        if (sb.size() != 0 || bm.busy) begin
            n_fail++;
            $display("FAIL %s_drain: pending=%0d busy=%b want 0/0",
                     name, sb.size(), bm.busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bm.in_valid = 0; bm.in_data = '0; bm.sel_ready = 0;
        bm.out_ready = '0; bm.cnt_clr = 0;
        bl.in_valid = 0; bl.in_data = '0; bl.sel_ready = 0;
        bl.out_ready = '0; bl.cnt_clr = 0;
        repeat (2) tick();
        n_checks++;
        if ({bm.in_ready, bm.sel_valid, bm.sel_data, bm.out_valid,
             bm.out_data, bm.pkt_count, bm.busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b sv=%b ov=%b od=%h cnt=%h busy=%b want all 0",
                     bm.in_ready, bm.sel_valid, bm.out_valid, bm.out_data,
                     bm.pkt_count, bm.busy);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (bm.in_ready !== 1'b1 || bm.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b busy=%b want 1/0",
                     bm.in_ready, bm.busy);
        end
    endtask

    task automatic test_nonleaf();
        bm.sel_ready = 1'b1;
        bm.out_ready = 2'b11;
        push_flit(9'h000);
        n_checks++;
        if (bm.sel_valid !== 1'b0 || bm.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL lat_edge0: sel_valid=%b busy=%b want 0/1",
                     bm.sel_valid, bm.busy);
        end
        tick();
        n_checks++;
        if (bm.sel_valid !== 1'b1 || bm.sel_data !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_edge1: sel_valid=%b sel_data=%b want 1/0",
                     bm.sel_valid, bm.sel_data);
        end
        tick();
        n_checks++;
        if (bm.out_valid !== 2'b01 || bm.sel_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_edge2: out_valid=%b sel_valid=%b want 01/0",
                     bm.out_valid, bm.sel_valid);
        end
        tick();
        n_checks++;
        if (bm.out_valid !== 2'b00 || bm.pkt_count !== 4'b0001) begin
            n_fail++;
            $display("FAIL lat_edge3: out_valid=%b cnt=%b want 00/0001",
                     bm.out_valid, bm.pkt_count);
        end
        push_flit(9'h040);
        wait_drain("nonleaf");
        n_checks++;
        if (bm.pkt_count !== 4'b0101) begin
            n_fail++;
            $display("FAIL nonleaf_count: got %b want 0101", bm.pkt_count);
        end
    endtask

    task automatic test_leaf();
        logic [8:0] d[2];
        logic       p[2];
        d[0] = 9'h0A0; p[0] = 1'b0;
        d[1] = 9'h100; p[1] = 1'b1;
        bl.out_ready = 2'b11;
        for (int k = 0; k < 2; k++) begin
            logic [1:0] ev;
            ev = 2'b01 << p[k];
            bl.sel_ready = 1'b0;
            bl.in_valid  = 1'b1;
            bl.in_data   = d[k];
            tick();
            bl.in_valid = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (bl.sel_valid) break;
                tick();
            end
            n_checks++;
            if (bl.sel_valid !== 1'b1 || bl.sel_data !== p[k] ||
                bl.out_valid !== 2'b00) begin
                n_fail++;
                $display("FAIL leaf_token%0d: sv=%b sd=%b ov=%b want 1/%b/00",
                         k, bl.sel_valid, bl.sel_data, bl.out_valid, p[k]);
            end
            bl.sel_ready = 1'b1;
            tick();
            n_checks++;
            if (bl.out_valid !== ev || bl.out_data !== d[k] ||
                bl.sel_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL leaf_flit%0d: ov=%b od=%h sv=%b want %b/%h/0",
                         k, bl.out_valid, bl.out_data, bl.sel_valid, ev, d[k]);
            end
            tick();
            n_checks++;
            if (bl.pkt_count[p[k]*16 +: 16] !== 16'd1) begin
                n_fail++;
                $display("FAIL leaf_count%0d: got %0d want 1",
                         k, bl.pkt_count[p[k]*16 +: 16]);
            end
        end
        bl.sel_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bm.sel_ready = 1'b1;
        bm.out_ready = 2'b11;
        deliv_cyc.delete();
        push_flit(9'h000);
        push_flit(9'h040);
        push_flit(9'h001);
        wait_drain("b2b");
        n_checks++;
        if (deliv_cyc.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d deliveries want 3",
                     deliv_cyc.size());
        end else if (deliv_cyc[1] - deliv_cyc[0] != 2 ||
                     deliv_cyc[2] - deliv_cyc[1] != 2) begin
            n_fail++;
            $display("FAIL b2b_rate: gaps %0d,%0d want 2,2",
                     deliv_cyc[1] - deliv_cyc[0], deliv_cyc[2] - deliv_cyc[1]);
        end
    endtask

    task automatic test_backpressure();
        bm.sel_ready = 1'b0;
        bm.out_ready = 2'b11;
        push_flit(9'h000);
        push_flit(9'h040);
        push_flit(9'h041);
        n_checks++;
        if (bm.in_ready !== 1'b0 || bm.sel_valid !== 1'b1 ||
            bm.sel_data !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: rdy=%b sv=%b sd=%b want 0/1/0",
                     bm.in_ready, bm.sel_valid, bm.sel_data);
        end
        bm.in_valid = 1'b1;
        bm.in_data  = 9'h1FF;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bm.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: in_ready=%b want 0", i, bm.in_ready);
            end
        end
        bm.in_valid  = 1'b0;
        bm.sel_ready = 1'b1;
        wait_drain("bp");
        n_checks++;
        if (bm.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b want 1", bm.in_ready);
        end
    endtask

    task automatic test_out_stall();
        bm.cnt_clr = 1'b1;
        tick();
        bm.cnt_clr   = 1'b0;
        bm.sel_ready = 1'b1;
        bm.out_ready = 2'b01;
        push_flit(9'h040);
        for (int i = 0; i < 20; i++) begin
            if (bm.out_valid != 2'b00) break;
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (bm.out_valid !== 2'b10 || bm.out_data !== 9'h040 ||
                bm.pkt_count !== 4'b0000) begin
                n_fail++;
                $display("FAIL stall%0d: ov=%b od=%h cnt=%b want 10/040/0000",
                         i, bm.out_valid, bm.out_data, bm.pkt_count);
            end
            tick();
        end
        bm.out_ready = 2'b11;
        wait_drain("stall");
        n_checks++;
        if (bm.pkt_count !== 4'b0100) begin
            n_fail++;
            $display("FAIL stall_count: got %b want 0100", bm.pkt_count);
        end
    endtask

    task automatic test_counter();
        logic [8:0] flits[5];
        flits[0] = 9'h000; flits[1] = 9'h011; flits[2] = 9'h022;
        flits[3] = 9'h03F; flits[4] = 9'h100;
        bm.sel_ready = 1'b1;
        bm.out_ready = 2'b11;
        bm.cnt_clr   = 1'b1;
        tick();
        bm.cnt_clr = 1'b0;
        foreach (flits[i]) push_flit(flits[i]);
        wait_drain("cnt");
        n_checks++;
        if (bm.pkt_count !== 4'b0011 || bm.pkt_count[1:0] !== 2'(exp_cnt[0])) begin
            n_fail++;
            $display("FAIL cnt_sat: got %b want 0011 (model %0d)",
                     bm.pkt_count, exp_cnt[0]);
        end
        bm.out_ready = 2'b00;
        push_flit(9'h000);
        for (int i = 0; i < 20; i++) begin
            if (bm.out_valid != 2'b00) break;
            tick();
        end
        n_checks++;
        if (bm.out_valid !== 2'b01 || bm.pkt_count !== 4'b0011) begin
            n_fail++;
            $display("FAIL cnt_pre: ov=%b cnt=%b want 01/0011",
                     bm.out_valid, bm.pkt_count);
        end
        bm.cnt_clr   = 1'b1;
        bm.out_ready = 2'b01;
        tick();
        bm.cnt_clr   = 1'b0;
        bm.out_ready = 2'b11;
        n_checks++;
        if (bm.pkt_count !== 4'b0000 || bm.out_valid !== 2'b00 ||
            exp_cnt[0] != 0) begin
            n_fail++;
            $display("FAIL cnt_clr_wins: cnt=%b ov=%b want 0000/00",
                     bm.pkt_count, bm.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bm.sel_ready = 1'b1;
        bm.out_ready = 2'b00;
        push_flit(9'h040);
        push_flit(9'h000);
        for (int i = 0; i < 20; i++) begin
            if (bm.out_valid != 2'b00) break;
            tick();
        end
        n_checks++;
        if (bm.out_valid !== 2'b10 || bm.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_pre: ov=%b busy=%b want 10/1",
                     bm.out_valid, bm.busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bm.in_ready, bm.sel_valid, bm.sel_data, bm.out_valid,
             bm.out_data, bm.pkt_count, bm.busy} !== '0) begin
            n_fail++;
            $display("FAIL rmid_outputs: rdy=%b sv=%b ov=%b od=%h cnt=%b busy=%b want all 0",
                     bm.in_ready, bm.sel_valid, bm.out_valid, bm.out_data,
                     bm.pkt_count, bm.busy);
        end
        sb.delete();
        tok_ok     = 1'b0;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        tick();
        rst_n        = 1'b1;
        bm.out_ready = 2'b11;
        repeat (2) tick();
        n_checks++;
        if (bm.busy !== 1'b0 || bm.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_after: busy=%b in_ready=%b want 0/1",
                     bm.busy, bm.in_ready);
        end
        push_flit(9'h040);
        wait_drain("rmid");
        n_checks++;
        if (bm.pkt_count !== 4'b0100) begin
            n_fail++;
            $display("FAIL rmid_count: got %b want 0100", bm.pkt_count);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        tok_ok   = 1'b0;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        test_reset();
        test_nonleaf();
        test_leaf();
        test_back_to_back();
        test_backpressure();
        test_out_stall();
        test_counter();
        test_reset_mid();
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/route_demux_buf.md
# route_demux_buf

Clocked, parametrised successor to the NoC tree-node decoder. It accepts flits on a valid/ready input and buffers them in a small FIFO. Each flit is steered to one of NUM_OUT output ports, using either tree-level address bits or a leaf address/mask match. For every flit a route-select token is emitted before the flit itself, and per-port packet counts are kept.

## Interface
Parameters:
- DATA_W, 9: flit width.
- ADDR_LSB, 5: bit position of the address field LSB inside the flit.
- ADDR_W, 4: address field width.
- NUM_OUT, 2: output ports; power of two, 2..8; must be 2 when LEAF=1.
- LEVEL, 0: tree level (non-leaf); requires (LEVEL+1)*SEL_W <= ADDR_W.
- LEAF, 0: 1 selects address/mask match mode.
- NODE_ADDR, 4'b0100: leaf match address (ADDR_W bits).
- NODE_MASK, 4'b1100: leaf match mask (ADDR_W bits).
- DEPTH, 2: input FIFO entries; power of two, >= 2.
- CNT_W, 16: per-port counter width.
- Derived: SEL_W = clog2(NUM_OUT).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input flit valid.
- in_ready  out  1  input accept; equals FIFO not full.
- in_data  in  DATA_W  input flit.
- sel_valid  out  1  route token valid.
- sel_ready  in  1  route token accept.
- sel_data  out  SEL_W  chosen port index.
- out_valid  out  NUM_OUT  one-hot output valid.
- out_ready  in  NUM_OUT  per-port accept.
- out_data  out  DATA_W  flit shared by all ports.
- cnt_clr  in  1  synchronous clear of all counters.
- pkt_count  out  NUM_OUT*CNT_W  per-port delivered-flit counts; port p occupies [p*CNT_W +: CNT_W].
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

## Operation
- **FIFO push:** on in_valid & in_ready.
- **FIFO pop:** only by the FSM, never on the same cycle as an empty push (no bypass).
- **Port computation** is done from the FIFO head at pop time:
  - Non-leaf: port = in_data[ADDR_LSB+ADDR_W-1-LEVEL*SEL_W -: SEL_W].
  - Leaf: port = ((addr & NODE_MASK) == NODE_ADDR) ? 0 : 1, where addr = in_data[ADDR_LSB +: ADDR_W].
- **FSM states:** IDLE, SEL, DATA.
  - IDLE: if the FIFO is non-empty, pop, load flit_reg and port_reg, go to SEL.
  - SEL: sel_valid=1 and sel_data=port_reg. On sel_ready, go to DATA.
  - DATA: out_valid[port_reg]=1, all other bits 0, out_data=flit_reg. On out_ready[port_reg]:
    - increment counter port_reg;
    - if the FIFO is non-empty, pop and load, go to SEL;
    - otherwise go to IDLE.
- **Ordering:** a token always completes strictly before its flit's valid rises. Flits leave in arrival order.
- **Valid hold:** valid, once raised, is held with stable data until the handshake completes. out_ready on non-selected ports is ignored.
- **Counters:** saturate at all-ones.
  - cnt_clr forces all counters to 0 and wins over a simultaneous increment.
- **Reset:** all outputs 0; in_ready goes to 1 after deassertion. FIFO emptied, FSM to IDLE, counters 0. In-flight flits are discarded, including one mid-handshake.

## Timing
- **Minimum latency:** flit accepted at edge 0 → popped at edge 1 → sel_valid high after edge 1 → sel handshake at edge 2 → out_valid high after edge 2 → delivered at edge 3.
- **Sustained throughput:** 1 flit per 2 cycles with sel_ready and out_ready held high (DATA→SEL direct).
- **Full FIFO:** in_ready=0 and in_valid is ignored. A pop frees a slot, so in_ready rises the following cycle.
- **Wrap-around:** FIFO pointers wrap modulo DEPTH. The full/empty distinction uses an extra pointer bit.
- **No combinational paths:** none from sel_ready or out_ready to in_ready, and none from in_valid to any output.

## Test plan
- **Non-leaf routing**, defaults with LEVEL=2 (decodes bit 6): send 9'h000 then 9'h040 with all readies high → sel_data 0 then 1; flits delivered on ports 0 then 1; pkt_count = {1,1}.
- **Leaf routing**, LEAF=1: send 9'h0A0 (addr 0101) → port 0; send 9'h100 (addr 1000) → port 1; tokens precede flits each time.
- **Backpressure:** sel_ready=0, push 3 flits with DEPTH=2:
  - first flit held in SEL;
  - next two fill the FIFO; in_ready=0 on cycle 4;
  - release sel_ready → all three flits delivered in order; in_ready returns to 1.
- **Output stall:** out_ready[1]=0 for 10 cycles on a port-1 flit → out_valid stays 2'b10, out_data stable, counter unchanged; then ready → counter 1.
- **Counter:** with CNT_W=2, deliver 5 flits to port 0 → count 3 (saturated). Assert cnt_clr in the same cycle as a delivery → count 0.
- **Reset mid-operation:** assert rst_n=0 while in DATA with the FIFO holding 1 entry → all outputs 0 immediately; after release busy=0, and a new flit routes normally.
